// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI write responder and its address generator.
package axi_pkg;

  localparam int MEM_BYTES = 4096;
  localparam int ADDR_BITS = 12;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    BRESP = 2'd2
  } state_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts in a 4 KiB space.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 3
) (
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [SIZE-1:0]      size,
  input  logic [WIDTH/8-1:0]   len,
  input  logic [SIZE-2:0]      burst,
  output logic [ADDR_BITS-1:0] next_addr
);

  localparam int EW = ADDR_BITS + 1;

  logic [EW-1:0] ext, bytes, blk, incr_addr, wrap_addr;

  always_comb begin
    ext       = {1'b0, addr};
    bytes     = EW'(1) << size;
    blk       = (EW'(len) + EW'(1)) * bytes;
    incr_addr = (ext & ~(bytes - EW'(1))) + bytes;
    // Keep the block base, advance only the offset inside the wrap block.
    wrap_addr = (ext & ~(blk - EW'(1))) | ((ext + bytes) & (blk - EW'(1)));
    case (burst_t'(2'(burst)))
      INCR:    next_addr = ADDR_BITS'(incr_addr);
      WRAP:    next_addr = ADDR_BITS'(wrap_addr);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_write_responder.sv
// Single-outstanding AXI write slave backed by a 4 KiB byte memory.
// state | meaning
// IDLE  | waiting for an AW handshake
// WDATA | accepting awlen+1 write beats
// BRESP | presenting the write response until bready
module axi_write_responder
  import axi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH/8-1:0]        awid,
  input  logic [WIDTH-1:0]          awaddr,
  input  logic [WIDTH/8-1:0]        awlen,
  input  logic [SIZE-1:0]           awsize,
  input  logic [SIZE-2:0]           awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [WIDTH/8-1:0]        wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [WIDTH/8-1:0]        bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [MEM_BYTES-1:0][7:0] slave_mem
);

  localparam int NB = WIDTH / 8;
  localparam logic [SIZE-1:0] MAX_SIZE = SIZE'($clog2(NB));

  state_t                   state, state_nx;
  logic [ADDR_BITS-1:0]     addr_q, addr_nx, base;
  logic [SIZE-1:0]          size_q;
  logic [SIZE-2:0]          burst_q;
  logic [NB-1:0]            len_q, beat_cnt, id_q, lane_we;
  logic                     cfg_err, wlast_err;
  resp_t                    resp_q;
  logic [MEM_BYTES-1:0][7:0] mem;
  logic                     aw_hs, w_hs, b_hs, last_beat;
  burst_t                   aw_kind;
  int                       lane_lo, lane_hi, beat_bytes;
  logic                     unused_addr_hi;

  assign unused_addr_hi = ^awaddr[WIDTH-1:ADDR_BITS];

  // awready is held low while reset is applied, and is up as soon as it drops.
  assign awready   = (state == IDLE) && !reset;
  assign wready    = (state == WDATA);
  assign bvalid    = (state == BRESP);
  assign bid       = id_q;
  assign bresp     = resp_q;
  assign slave_mem = mem;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign last_beat = (beat_cnt == len_q);
  assign aw_kind   = burst_t'(2'(awburst));

  axi_burst_addr_gen #(.WIDTH(WIDTH), .SIZE(SIZE)) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (addr_nx)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (aw_hs) state_nx = WDATA;
      WDATA:   if (w_hs && last_beat) state_nx = BRESP;
      BRESP:   if (b_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane window runs from the beat's byte offset to the end of its size-aligned chunk.
  always_comb begin
    lane_we    = '0;
    base       = addr_q & ~ADDR_BITS'(NB - 1);
    beat_bytes = 1 << size_q;
    lane_lo    = int'(addr_q) % NB;
    lane_hi    = ((int'(addr_q) & ~(beat_bytes - 1)) % NB) + beat_bytes - 1;
    for (int i = 0; i < NB; i++) begin
      if (w_hs && !cfg_err && wstrb[i] && i >= lane_lo && i <= lane_hi) lane_we[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem       <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      id_q      <= '0;
      cfg_err   <= 1'b0;
      wlast_err <= 1'b0;
      resp_q    <= OKAY;
    end else begin
      state <= state_nx;
      if (aw_hs) begin
        id_q      <= awid;
        addr_q    <= awaddr[ADDR_BITS-1:0];
        len_q     <= awlen;
        size_q    <= awsize;
        burst_q   <= awburst;
        beat_cnt  <= '0;
        wlast_err <= 1'b0;
        cfg_err   <= (awsize > MAX_SIZE) || (aw_kind == RSVD) ||
                     ((aw_kind == WRAP) && !wrap_len_ok(8'(awlen)));
      end
      if (w_hs) begin
        beat_cnt <= beat_cnt + NB'(1);
        addr_q   <= addr_nx;
        if (wlast != last_beat) wlast_err <= 1'b1;
        if (last_beat)
          resp_q <= (cfg_err || wlast_err || !wlast) ? SLVERR : OKAY;
        for (int i = 0; i < NB; i++) begin
          if (lane_we[i]) mem[base + ADDR_BITS'(i)] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_write_responder.sv
// Randomized and directed bench for axi_write_responder against a byte-array reference model.
module tb_axi_write_responder;
  import axi_pkg::*;

  localparam int WIDTH = 32;
  localparam int SIZE  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        awid;
  logic [31:0]       awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid, awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast, wvalid, wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid, bready;
  logic [4095:0][7:0] slave_mem;

  always #5 clk = ~clk;

  axi_write_responder #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .slave_mem(slave_mem)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_mem [4096];
  logic [31:0] beat_data [16];
  logic [3:0]  beat_strb [16];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Address of beat k straight from the burst definition.
  function automatic int beat_addr(int start, int size, int len, int burst, int k);
    int nb, blk, low;
    nb = 1 << size;
    if (burst == 0) return start;
    if (burst == 1) return (k == 0) ? start : ((start / nb) * nb + k * nb) % 4096;
    blk = (len + 1) * nb;
    low = (start / blk) * blk;
    return low + ((start - low) + k * nb) % blk;
  endfunction

  task automatic model_beat(input int a, input int size, input logic [31:0] d, input logic [3:0] s);
    int nb, lo, hi;
    nb = 1 << size;
    lo = a % 4;
    hi = ((a / nb) * nb) % 4 + nb - 1;
    for (int i = 0; i < 4; i++)
      if (s[i] && i >= lo && i <= hi) exp_mem[((a / 4) * 4 + i) % 4096] = d[8*i +: 8];
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 4096; i++) if (slave_mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] mem_word(int a);
    return {slave_mem[(a + 3) % 4096], slave_mem[(a + 2) % 4096],
            slave_mem[(a + 1) % 4096], slave_mem[a % 4096]};
  endfunction

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int bad_wlast,
                           input int bready_wait, input int abort_at, input bit gaps);
    bit cfg_err, wl_err;
    int n, start;
    start   = int'(addr[11:0]);
    cfg_err = (size > 2) || (burst == 3) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    wl_err  = (bad_wlast >= 0);
    // stray write beat in IDLE must be ignored
    @(negedge clk);
    wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF; wlast = 1'b1;
    check_eq("wready_idle", wready, 0);
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk);
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check_eq("aw_timeout", n < 20, 1);
    @(posedge clk); #1;
    awid = $urandom; awaddr = $urandom; awburst = 2'd1;
    @(negedge clk);
    check_eq("wready_rise", wready, 1);
    check_eq("awready_busy", awready, 0);
    for (int k = 0; k <= len; k++) begin
      if (k == abort_at) begin
        reset = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check_eq("abort_bvalid", bvalid, 0);
        @(negedge clk);
        check_eq("abort_bvalid2", bvalid, 0);
        for (int i = 0; i < 4096; i++) exp_mem[i] = 8'h00;
        check_eq("abort_mem", mem_diffs(), 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_awready", awready, 1);
        check_eq("abort_bvalid3", bvalid, 0);
        return;
      end
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
      wvalid = 1'b1; wdata = beat_data[k]; wstrb = beat_strb[k];
      wlast = (k == len) ^ (k == bad_wlast);
      n = 0;
      while (!wready && n < 20) begin @(negedge clk); n++; end
      check_eq("w_timeout", n < 20, 1);
      if (k == len) awvalid = 1'b0;
      @(posedge clk); #1;
      if (!cfg_err) model_beat(beat_addr(start, size, len, burst, k), size, beat_data[k], beat_strb[k]);
      wvalid = 1'b0;
      @(negedge clk);
    end
    check_eq("bvalid_rise", bvalid, 1);
    check_eq("wready_drop", wready, 0);
    for (int w = 0; w < bready_wait; w++) begin
      wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF;
      check_eq("bvalid_hold", bvalid, 1);
      check_eq("bid_hold", bid, id);
      @(negedge clk);
    end
    wvalid = 1'b0;
    bready = 1'b1;
    check_eq("bid", bid, id);
    check_eq("bresp", bresp, (cfg_err || wl_err) ? 2'b10 : 2'b00);
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk);
    check_eq("awready_back", awready, 1);
    check_eq("mem", mem_diffs(), 0);
  endtask

  task automatic fill_random(input int len);
    for (int k = 0; k <= len; k++) begin
      beat_data[k] = $urandom;
      beat_strb[k] = 4'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_awready", awready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_bid", bid, 0);
    check_eq("rst_bresp", bresp, 0);
    check_eq("rst_mem", mem_diffs(), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_release_awready", awready, 1);

    // INCR word burst
    for (int k = 0; k < 4; k++) begin beat_data[k] = 32'h11111111 * (k + 1); beat_strb[k] = 4'hF; end
    run_burst(4'h5, 32'h10, 3, 2, 1, -1, 0, -1, 1'b0);
    check_eq("incr_w0", mem_word(32'h10), 32'h11111111);
    check_eq("incr_w3", mem_word(32'h1C), 32'h44444444);

    // WRAP 0x38 -> 0x38, 0x3C, 0x30, 0x34
    for (int k = 0; k < 4; k++) begin beat_data[k] = 32'hA0A0A000 + k; beat_strb[k] = 4'hF; end
    run_burst(4'h6, 32'h38, 3, 2, 2, -1, 0, -1, 1'b1);
    check_eq("wrap_b0", mem_word(32'h38), 32'hA0A0A000);
    check_eq("wrap_b1", mem_word(32'h3C), 32'hA0A0A001);
    check_eq("wrap_b2", mem_word(32'h30), 32'hA0A0A002);
    check_eq("wrap_b3", mem_word(32'h34), 32'hA0A0A003);

    // FIXED byte burst: only mem[0x100] changes
    for (int k = 0; k < 3; k++) begin beat_data[k] = 32'hC3C2C100 + 32'(k * 17); beat_strb[k] = 4'hF; end
    run_burst(4'h7, 32'h100, 2, 0, 0, -1, 0, -1, 1'b0);
    check_eq("fixed_b0", slave_mem[12'h100], 8'h22);
    check_eq("fixed_b1", slave_mem[12'h101], 8'h00);

    // illegal size and reserved burst; the second one stalls bready for 5 cycles
    fill_random(2);
    run_burst(4'h8, 32'h200, 2, 3, 1, -1, 0, -1, 1'b0);
    fill_random(1);
    run_burst(4'h9, 32'h300, 1, 2, 3, -1, 5, -1, 1'b1);

    // early wlast on beat 2 of 4
    fill_random(3);
    run_burst(4'hA, 32'h400, 3, 2, 1, 1, 2, -1, 1'b0);

    // INCR across the top of the address space
    beat_data[0] = 32'hDEADBEEF; beat_data[1] = 32'h0BADF00D; beat_strb[0] = 4'hF; beat_strb[1] = 4'hF;
    run_burst(4'hB, 32'hFFC, 1, 2, 1, -1, 0, -1, 1'b0);
    check_eq("incr_wrap0", mem_word(0), 32'h0BADF00D);
    check_eq("incr_top", mem_word(32'hFFC), 32'hDEADBEEF);

    // reset in the middle of a data phase
    fill_random(3);
    run_burst(4'hC, 32'h500, 3, 2, 1, -1, 0, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int len, size, burst, bad;
      len   = $urandom_range(0, 15);
      size  = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      bad   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
      fill_random(len);
      run_burst(4'($urandom), $urandom, len, size, burst, bad, $urandom_range(0, 3), -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
